// File: rtl/mem_port_arbiter_if.sv
// Cache-to-memory miss port bundle: I-side, D-side and slow-memory signals.
// slave = arbiter view, master = caches/memory environment view.
interface mem_port_arbiter_if #(
  parameter int AW = 28,
  parameter int DW = 128
);
  logic          i_read;
  logic          i_write;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_wdata;
  logic [DW-1:0] i_rdata;
  logic          i_ready;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ready;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  modport slave (
    input  i_read, i_write, i_addr, i_wdata,
    output i_rdata, i_ready,
    input  d_read, d_write, d_addr, d_wdata,
    output d_rdata, d_ready,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport master (
    output i_read, i_write, i_addr, i_wdata,
    input  i_rdata, i_ready,
    output d_read, d_write, d_addr, d_wdata,
    input  d_rdata, d_ready,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one slow-memory line port between I and D caches.
// Ports: clk, rst (async, active-low), bus (slave modport), err (sticky watchdog).
module mem_port_arbiter #(
  parameter int AW     = 28,
  parameter int DW     = 128,
  parameter int TO_CYC = 1023
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus,
  output logic               err
);

  localparam int CW = $clog2(TO_CYC + 1);
  localparam logic [CW-1:0] LIM = CW'(TO_CYC);

  typedef enum logic [1:0] {
    IDLE,
    GNT_I,
    GNT_D
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic          last_d;
  logic          last_d_nx;
  logic          req_i;
  logic          req_d;
  logic          gnt_i;
  logic          gnt_d;
  logic [CW-1:0] wd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      last_d <= 1'b0;
    end else begin
      state  <= state_nx;
      last_d <= last_d_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    last_d_nx   = last_d;
    gnt_i       = 1'b0;
    gnt_d       = 1'b0;
    bus.i_ready = 1'b0;
    bus.d_ready = 1'b0;
    bus.i_rdata = '0;
    bus.d_rdata = '0;
    req_i       = bus.i_read | bus.i_write;
    req_d       = bus.d_read | bus.d_write;
    unique case (state)
      IDLE: begin
        // On a tie the side not served last wins.
        gnt_d = req_d & (~req_i | ~last_d);
        gnt_i = req_i & ~gnt_d;
        if (gnt_i) begin
          state_nx  = GNT_I;
          last_d_nx = 1'b0;
        end else if (gnt_d) begin
          state_nx  = GNT_D;
          last_d_nx = 1'b1;
        end
      end
      GNT_I: begin
        bus.i_ready = bus.mem_ready;
        bus.i_rdata = bus.mem_rdata;
        if (bus.mem_ready) state_nx = IDLE;
      end
      GNT_D: begin
        bus.d_ready = bus.mem_ready;
        bus.d_rdata = bus.mem_rdata;
        if (bus.mem_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Read together with write is issued as a write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.mem_read  <= 1'b0;
      bus.mem_write <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else if (gnt_i) begin
      bus.mem_read  <= bus.i_read & ~bus.i_write;
      bus.mem_write <= bus.i_write;
      bus.mem_addr  <= bus.i_addr;
      bus.mem_wdata <= bus.i_wdata;
    end else if (gnt_d) begin
      bus.mem_read  <= bus.d_read & ~bus.d_write;
      bus.mem_write <= bus.d_write;
      bus.mem_addr  <= bus.d_addr;
      bus.mem_wdata <= bus.d_wdata;
    end else if (state != IDLE && bus.mem_ready) begin
      bus.mem_read  <= 1'b0;
      bus.mem_write <= 1'b0;
    end
  end

  // Watchdog saturates; the stuck transaction keeps waiting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd  <= '0;
      err <= 1'b0;
    end else if (state == IDLE) begin
      wd <= '0;
    end else if (!bus.mem_ready) begin
      if (wd != LIM) wd <= wd + 1'b1;
      if (wd == LIM - 1'b1) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table plus
// hand sequences for fairness, write latching, watchdog and reset.
module tb_mem_port_arbiter;

  localparam int AW = 28;
  localparam int DW = 128;
  localparam int TO = 1023;

  localparam logic [AW-1:0] IA  = 28'h1111111;
  localparam logic [AW-1:0] DA  = 28'h0000010;
  localparam logic [AW-1:0] DA2 = 28'h0ABCDEF;
  localparam logic [DW-1:0] WD  = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
  localparam logic [DW-1:0] MRD = 128'hCAFE_0000_BEEF_0000_DEAD_0000_F00D_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic err;
  int   checks = 0;
  int   errors = 0;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(.AW(AW), .DW(DW), .TO_CYC(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave),
    .err (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          ir, iw, dr, dw, mr;
    logic [1:0]    st;
    logic          emr, emw;
    logic [AW-1:0] ea;
  } vec_t;

  vec_t v[15];

  function automatic vec_t mk(logic ir, logic iw, logic dr, logic dw,
                              logic mr, logic [1:0] st, logic emr,
                              logic emw, logic [AW-1:0] ea);
    vec_t r;
    r.ir = ir; r.iw = iw; r.dr = dr; r.dw = dw; r.mr = mr;
    r.st = st; r.emr = emr; r.emw = emw; r.ea = ea;
    return r;
  endfunction

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(logic ir, logic iw, logic dr, logic dw, logic mr);
    bus.i_read = ir; bus.i_write = iw;
    bus.d_read = dr; bus.d_write = dw;
    bus.mem_ready = mr;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0);
    bus.i_addr = IA; bus.d_addr = DA;
    bus.i_wdata = ~WD; bus.d_wdata = WD;
    bus.mem_rdata = MRD;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] st;
    int ntx, held, idle;
    logic prev, exp_d;

    v[0]  = mk(0,0,1,0,0, 0, 0,0, 28'h0);
    v[1]  = mk(0,0,1,0,0, 2, 1,0, DA);
    v[2]  = mk(0,0,1,0,0, 2, 1,0, DA);
    v[3]  = mk(0,0,1,0,0, 2, 1,0, DA);
    v[4]  = mk(0,0,1,0,1, 2, 1,0, DA);
    v[5]  = mk(0,0,1,1,0, 0, 0,0, DA);
    v[6]  = mk(0,0,1,1,0, 2, 0,1, DA);
    v[7]  = mk(0,0,1,1,1, 2, 0,1, DA);
    v[8]  = mk(0,0,0,0,1, 0, 0,0, DA);
    v[9]  = mk(1,0,0,0,0, 0, 0,0, DA);
    v[10] = mk(1,0,1,0,0, 1, 1,0, IA);
    v[11] = mk(1,0,1,0,1, 1, 1,0, IA);
    v[12] = mk(0,0,1,0,0, 0, 0,0, IA);
    v[13] = mk(0,0,1,0,1, 2, 1,0, DA);
    v[14] = mk(0,0,0,0,0, 0, 0,0, DA);

    // Reset state, checked while rst is held low.
    rst = 1'b0;
    drive(0, 0, 0, 0, 1);
    bus.i_addr = IA; bus.d_addr = DA;
    bus.i_wdata = ~WD; bus.d_wdata = WD;
    bus.mem_rdata = MRD;
    @(negedge clk);
    chk("rst mem_read", bus.mem_read, 0);
    chk("rst mem_write", bus.mem_write, 0);
    chk("rst mem_addr", bus.mem_addr, 0);
    chk("rst mem_wdata", bus.mem_wdata, 0);
    chk("rst err", err, 0);
    chk("rst i_ready", bus.i_ready, 0);
    chk("rst d_ready", bus.d_ready, 0);

    // Vector table.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      drive(v[i].ir, v[i].iw, v[i].dr, v[i].dw, v[i].mr);
      bus.mem_rdata = MRD + DW'(i);
      @(negedge clk);
      st = v[i].st;
      chk($sformatf("v%0d mem_read", i), bus.mem_read, v[i].emr);
      chk($sformatf("v%0d mem_write", i), bus.mem_write, v[i].emw);
      chk($sformatf("v%0d mem_addr", i), bus.mem_addr, v[i].ea);
      chk($sformatf("v%0d i_ready", i), bus.i_ready, (st == 1) & v[i].mr);
      chk($sformatf("v%0d d_ready", i), bus.d_ready, (st == 2) & v[i].mr);
      chk($sformatf("v%0d i_rdata", i), bus.i_rdata,
          (st == 1) ? MRD + DW'(i) : '0);
      chk($sformatf("v%0d d_rdata", i), bus.d_rdata,
          (st == 2) ? MRD + DW'(i) : '0);
      @(posedge clk);
      #1;
    end

    // Both sides request continuously: D,I,D,I,D,I with one idle cycle.
    do_reset();
    drive(1, 0, 1, 0, 0);
    ntx = 0; held = 0; idle = 0; prev = 1'b0;
    for (int c = 0; c < 100 && ntx < 6; c++) begin
      @(negedge clk);
      exp_d = (ntx % 2 == 0);
      if (bus.mem_read) begin
        if (!prev) begin
          chk($sformatf("rr%0d order", ntx), bus.mem_addr == DA, exp_d);
          if (ntx > 0) chk($sformatf("rr%0d gap", ntx), idle, 1);
        end
        held++;
        if (held == 3) begin
          bus.mem_ready = 1'b1;
          #1;
          chk($sformatf("rr%0d d_ready", ntx), bus.d_ready, exp_d);
          chk($sformatf("rr%0d i_ready", ntx), bus.i_ready, !exp_d);
          ntx++;
        end else begin
          bus.mem_ready = 1'b0;
        end
      end else begin
        idle = prev ? 1 : idle + 1;
        held = 0;
        bus.mem_ready = 1'b0;
      end
      prev = bus.mem_read;
    end
    chk("rr count", ntx, 6);
    drive(0, 0, 0, 0, 0);

    // D write latched while I waits.
    do_reset();
    bus.d_addr = DA2;
    drive(1, 0, 0, 1, 0);
    @(posedge clk);
    #1;
    bus.d_wdata = ~WD;
    bus.d_addr = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("wr%0d mem_write", k), bus.mem_write, 1);
      chk($sformatf("wr%0d mem_read", k), bus.mem_read, 0);
      chk($sformatf("wr%0d mem_wdata", k), bus.mem_wdata, WD);
      chk($sformatf("wr%0d mem_addr", k), bus.mem_addr, DA2);
    end
    bus.mem_ready = 1'b1;
    #1;
    chk("wr d_ready", bus.d_ready, 1);
    chk("wr i_ready", bus.i_ready, 0);
    @(posedge clk);
    #1;
    drive(1, 0, 0, 0, 0);
    @(negedge clk);
    chk("wr idle mem_write", bus.mem_write, 0);
    @(negedge clk);
    chk("wr next mem_read", bus.mem_read, 1);
    chk("wr next mem_addr", bus.mem_addr, IA);
    bus.mem_ready = 1'b1;
    #1;
    chk("wr next i_ready", bus.i_ready, 1);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0);

    // Watchdog, then reset in the middle of GNT_I.
    do_reset();
    bus.d_addr = DA;
    drive(1, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    chk("wdg grant", bus.mem_read, 1);
    repeat (TO - 20) @(negedge clk);
    chk("wdg early err", err, 0);
    repeat (30) @(negedge clk);
    chk("wdg err set", err, 1);
    chk("wdg pending", bus.mem_read, 1);
    bus.mem_ready = 1'b1;
    #1;
    chk("wdg i_ready", bus.i_ready, 1);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("wdg sticky", err, 1);
    chk("wdg done", bus.mem_read, 0);
    @(posedge clk);
    #1;
    drive(1, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    chk("mid grant", bus.mem_read, 1);
    bus.mem_ready = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk("mid mem_read", bus.mem_read, 0);
    chk("mid mem_write", bus.mem_write, 0);
    chk("mid mem_addr", bus.mem_addr, 0);
    chk("mid mem_wdata", bus.mem_wdata, 0);
    chk("mid err", err, 0);
    chk("mid i_ready", bus.i_ready, 0);
    chk("mid i_rdata", bus.i_rdata, 0);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post idle", bus.mem_read, 0);
    chk("post ready", bus.i_ready, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
